model_read_weighting_scheduler: RTL and testbench

Sequencing controller for the DNC read-weighting datapath: w(t;i,j) = pi(t;i)[1]·b + pi(t;i)[2]·c + pi(t;i)[3]·f.
- For each read head i in 0..R-1, runs three multiply/accumulate passes (p = 0,1,2) over one shared vector float multiplier and one shared vector float adder.
- Drives start pulses, operand select, accumulator clear and loop indices.
- Sits between the DNC memory top level and the vector arithmetic units.

---
 rtl/model_read_weighting_scheduler.sv | 126 ++++++++++++
 tb/tb_model_read_weighting_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/model_read_weighting_scheduler.sv
// Sequences the DNC read-weighting passes w = pi1*b + pi2*c + pi3*f per read head
// over one shared vector multiplier and one shared vector adder.
module model_read_weighting_scheduler #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    BUSY,
  input  logic [DATA_SIZE-1:0]    SIZE_R_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_N_IN,
  output logic [DATA_SIZE-1:0]    SIZE_N_OUT,
  output logic                    MUL_START,
  input  logic                    MUL_READY,
  output logic                    ADD_START,
  input  logic                    ADD_READY,
  output logic [1:0]              OPERAND_SEL,
  output logic                    ACC_CLEAR,
  output logic [CONTROL_SIZE-1:0] INDEX_I,
  output logic [1:0]              INDEX_P,
  output logic                    ROW_VALID
);

  // state    | meaning
  // IDLE     | waiting for START
  // MUL_GO   | multiplier start pulse for term p
  // MUL_WAIT | waiting for multiplier done
  // ADD_GO   | adder start pulse, accumulate term p
  // ADD_WAIT | waiting for adder done
  // DONE     | run finished, READY pulse issued on exit
  typedef enum logic [2:0] {
    S_IDLE, S_MUL_GO, S_MUL_WAIT, S_ADD_GO, S_ADD_WAIT, S_DONE
  } state_t;

  localparam int CMP_W = (DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE;

  state_t               state;
  logic [DATA_SIZE-1:0] size_r;
  logic [CMP_W-1:0]     next_i_ext;
  logic [CMP_W-1:0]     size_r_ext;

  assign next_i_ext = CMP_W'(INDEX_I) + CMP_W'(1);
  assign size_r_ext = CMP_W'(size_r);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      size_r      <= '0;
      SIZE_N_OUT  <= '0;
      READY       <= 1'b0;
      BUSY        <= 1'b0;
      MUL_START   <= 1'b0;
      ADD_START   <= 1'b0;
      OPERAND_SEL <= 2'd0;
      ACC_CLEAR   <= 1'b0;
      INDEX_I     <= '0;
      INDEX_P     <= 2'd0;
      ROW_VALID   <= 1'b0;
    end else begin
      MUL_START <= 1'b0;
      ADD_START <= 1'b0;
      ROW_VALID <= 1'b0;
      READY     <= 1'b0;
      // Head index advances one cycle after ROW_VALID so the pulse carries the finished row.
      if (ROW_VALID)
        INDEX_I <= INDEX_I + CONTROL_SIZE'(1);
      case (state)
        S_IDLE: begin
          if (START) begin
            size_r      <= SIZE_R_IN;
            SIZE_N_OUT  <= SIZE_N_IN;
            INDEX_I     <= '0;
            INDEX_P     <= 2'd0;
            BUSY        <= 1'b1;
            if (SIZE_R_IN == '0) begin
              state <= S_DONE;
            end else begin
              state       <= S_MUL_GO;
              MUL_START   <= 1'b1;
              OPERAND_SEL <= 2'd0;
            end
          end
        end
        S_MUL_GO: state <= S_MUL_WAIT;
        S_MUL_WAIT: begin
          if (MUL_READY) begin
            state     <= S_ADD_GO;
            ADD_START <= 1'b1;
            ACC_CLEAR <= (INDEX_P == 2'd0);
          end
        end
        S_ADD_GO: state <= S_ADD_WAIT;
        S_ADD_WAIT: begin
          if (ADD_READY) begin
            ACC_CLEAR <= 1'b0;
            if (INDEX_P != 2'd2) begin
              INDEX_P     <= INDEX_P + 2'd1;
              OPERAND_SEL <= INDEX_P + 2'd1;
              MUL_START   <= 1'b1;
              state       <= S_MUL_GO;
            end else begin
              ROW_VALID <= 1'b1;
              INDEX_P   <= 2'd0;
              if (next_i_ext == size_r_ext) begin
                state <= S_DONE;
              end else begin
                OPERAND_SEL <= 2'd0;
                MUL_START   <= 1'b1;
                state       <= S_MUL_GO;
              end
            end
          end
        end
        S_DONE: begin
          READY <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_read_weighting_scheduler.sv
// Scoreboard bench: expected unit-start / row / ready events are queued per run and
// popped by a monitor thread; behavioural unit models answer the start pulses.
module tb_model_read_weighting_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b1;
  logic        READY, BUSY;
  logic [63:0] SIZE_R_IN = 64'd0;
  logic [63:0] SIZE_N_IN = 64'd0;
  logic [63:0] SIZE_N_OUT;
  logic        MUL_START, MUL_READY, ADD_START, ADD_READY;
  logic [1:0]  OPERAND_SEL;
  logic        ACC_CLEAR;
  logic [63:0] INDEX_I;
  logic [1:0]  INDEX_P;
  logic        ROW_VALID;

  logic mul_u = 1'b0, add_u = 1'b0, add_spur = 1'b0, hold_mul = 1'b0, spur_en = 1'b0;
  int   mul_d = 1, add_d = 1;
  int   tests = 0, fails = 0;

  assign MUL_READY = mul_u | hold_mul;
  assign ADD_READY = add_u | add_spur;

  localparam int K_MUL = 0, K_ADD = 1, K_ROW = 2, K_RDY = 3;
  typedef struct {
    int          kind;
    logic [63:0] a, b, c;
  } ev_t;
  ev_t exp_q[$];

  model_read_weighting_scheduler #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .BUSY(BUSY),
    .SIZE_R_IN(SIZE_R_IN), .SIZE_N_IN(SIZE_N_IN), .SIZE_N_OUT(SIZE_N_OUT),
    .MUL_START(MUL_START), .MUL_READY(MUL_READY),
    .ADD_START(ADD_START), .ADD_READY(ADD_READY),
    .OPERAND_SEL(OPERAND_SEL), .ACC_CLEAR(ACC_CLEAR),
    .INDEX_I(INDEX_I), .INDEX_P(INDEX_P), .ROW_VALID(ROW_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input string nm, input int kind, input logic [63:0] a, b, c);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s unexpected event: a=%0d b=%0d c=%0d", nm, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b || e.c !== c) begin
        fails++;
        $display("FAIL %s: got kind=%0d a=%0d b=%0d c=%0d expected kind=%0d a=%0d b=%0d c=%0d",
                 nm, kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  task automatic push(input int kind, input logic [63:0] a, b, c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  // Same-cycle order: a finished row precedes the next head's multiplier start.
  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (ROW_VALID) expect_ev("row_valid", K_ROW, INDEX_I, 0, 0);
        if (MUL_START) expect_ev("mul_start", K_MUL, 64'(OPERAND_SEL), 64'(INDEX_P), 0);
        if (ADD_START) expect_ev("add_start", K_ADD, 64'(ACC_CLEAR), INDEX_I, 64'(INDEX_P));
        if (READY)     expect_ev("ready", K_RDY, SIZE_N_OUT, 0, 0);
      end
    end
  endtask

  task automatic mul_unit();
    forever begin
      @(negedge CLK);
      if (!RST && MUL_START) begin
        repeat (mul_d) @(negedge CLK);
        mul_u = 1'b1;
        @(negedge CLK);
        mul_u = 1'b0;
      end
    end
  endtask

  task automatic add_unit();
    forever begin
      @(negedge CLK);
      if (!RST && ADD_START) begin
        repeat (add_d) @(negedge CLK);
        add_u = 1'b1;
        @(negedge CLK);
        add_u = 1'b0;
      end
    end
  endtask

  // Stray adder done raised during the multiplier phase of every term.
  task automatic spur_unit();
    forever begin
      @(negedge CLK);
      if (spur_en && MUL_START) begin
        add_spur = 1'b1;
        repeat (2) @(negedge CLK);
        add_spur = 1'b0;
      end
    end
  endtask

  task automatic load_expect(input int r, input logic [63:0] n);
    for (int i = 0; i < r; i++)
      for (int p = 0; p < 3; p++) begin
        push(K_MUL, p, p, 0);
        push(K_ADD, (p == 0) ? 1 : 0, i, p);
        if (p == 2) push(K_ROW, i, 0, 0);
      end
    push(K_RDY, n, 0, 0);
  endtask

  task automatic run(input int r, input int dm, input int da, input bit repulse);
    logic [63:0] n;
    int cyc, lat;
    bit busy_ok, done;
    n = {$urandom, $urandom};
    mul_d = dm; add_d = da;
    load_expect(r, n);
    @(negedge CLK);
    SIZE_R_IN = 64'(r); SIZE_N_IN = n; START = 1'b1;
    @(posedge CLK);
    cyc = 0; busy_ok = 1'b1; done = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge CLK);
      if (READY) begin
        done = 1'b1;
        START = 1'b0;
      end else begin
        if (!BUSY) busy_ok = 1'b0;
        START = repulse && (cyc % 7 == 3);
        SIZE_R_IN = {$urandom, $urandom};
        SIZE_N_IN = {$urandom, $urandom};
        @(posedge CLK);
        cyc++;
      end
    end
    START = 1'b0;
    chk("ready_seen", 64'(done), 1);
    lat = cyc + 1;
    chk("latency", 64'(lat), 64'((r == 0) ? 2 : 3 * r * (2 + dm + da) + 2));
    chk("busy_during_run", 64'(busy_ok), 1);
    repeat (12) @(negedge CLK);
    chk("busy_after_run", 64'(BUSY), 0);
    chk("queue_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(READY), 0);
    chk({tag, "_busy"}, 64'(BUSY), 0);
    chk({tag, "_mul_start"}, 64'(MUL_START), 0);
    chk({tag, "_add_start"}, 64'(ADD_START), 0);
    chk({tag, "_acc_clear"}, 64'(ACC_CLEAR), 0);
    chk({tag, "_row_valid"}, 64'(ROW_VALID), 0);
    chk({tag, "_index_i"}, INDEX_I, 0);
    chk({tag, "_index_p"}, 64'(INDEX_P), 0);
    chk({tag, "_operand_sel"}, 64'(OPERAND_SEL), 0);
    chk({tag, "_size_n_out"}, SIZE_N_OUT, 0);
  endtask

  initial begin
    int  k;
    bit  hit;
    fork
      monitor();
      mul_unit();
      add_unit();
      spur_unit();
    join_none

    // Reset held with START high
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    START = 1'b0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    run(1, 1, 1, 1'b0);
    run(3, 5, 2, 1'b0);
    run(0, 1, 1, 1'b0);

    // Multiplier done held high, stray adder done, START re-pulsed while busy
    hold_mul = 1'b1; spur_en = 1'b1;
    run(2, 1, 1, 1'b1);
    hold_mul = 1'b0; spur_en = 1'b0;
    repeat (4) @(negedge CLK);

    for (k = 0; k < 6; k++)
      run($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3), k[0]);

    // Abort in ADD_WAIT of head 1, term 2
    mul_d = 2; add_d = 3;
    load_expect(3, 64'd77);
    @(negedge CLK);
    SIZE_R_IN = 64'd3; SIZE_N_IN = 64'd77; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge CLK);
      if (ADD_START && INDEX_I == 64'd1 && INDEX_P == 2'd2) hit = 1'b1;
    end
    chk("abort_point_reached", 64'(hit), 1);
    @(negedge CLK);
    RST = 1'b1; START = 1'b1;
    #1;
    exp_q.delete();
    check_reset_outputs("abort");
    repeat (2) @(negedge CLK);
    START = 1'b0;
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    chk("no_events_after_abort", 64'(exp_q.size()), 0);
    run(2, 1, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
